shared_mem_arbiter: RTL

- Parametrised N-port arbiter granting multiple bus masters (68K, Z80, VDP DMA, future masters) one-at-a-time access to a single shared synchronous RAM.
- Generalises the two-master RAM front end:
  - configurable port count, address and data widths, and RAM read latency
  - byte-lane write enables
  - round-robin or fixed-priority arbitration
  - a uniform req/ack handshake per port
- Sits between the CPU bus adapters and the block RAM.

---
 rtl/shared_mem_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: N-port front end for one synchronous RAM.
// Every master raises req with its access fields held stable. The arbiter
// serves one port at a time through IDLE -> ISSUE -> WAIT -> DONE and pulses
// that port's ack for one cycle when the access completes.
//
// Handshake: a port holds req, we, addr, wdata and be stable until ack is high
// for that port. ack lasts exactly one cycle. If req is still high in the
// following cycle, it counts as a new request.
//
// The FSM state is held in the `state` register so checkers can bind to it.
// busy is its externally visible summary: high whenever state != IDLE.
module shared_mem_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 16,
  parameter int RAM_LATENCY = 1,
  parameter int ARB_MODE    = 0,
  localparam int BE_W       = DATA_W / 8,
  localparam int GID_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  input  logic [NUM_PORTS*BE_W-1:0]   be,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [NUM_PORTS*DATA_W-1:0] rdata,
  output logic                        ram_en,
  output logic                        ram_we,
  output logic [BE_W-1:0]             ram_be,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_wdata,
  input  logic [DATA_W-1:0]           ram_rdata,
  output logic                        busy,
  output logic [GID_W-1:0]            grant_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The counter only has to reach RAM_LATENCY, which is at most 4.
  localparam logic [2:0] LAT_END = 3'(RAM_LATENCY);

  state_t           state;
  logic [2:0]       lat_cnt;
  logic [GID_W-1:0] last;
  logic [GID_W-1:0] start_ptr;
  logic [GID_W-1:0] cand;
  logic [GID_W-1:0] winner;

  // Pick the winner. The scan starts just after start_ptr and wraps. Fixed
  // priority uses the same scan with start_ptr pinned to the top index, so
  // port 0 is always looked at first.
  always_comb begin
    start_ptr = (ARB_MODE != 0) ? GID_W'(NUM_PORTS - 1) : last;
    cand      = '0;
    winner    = '0;
    // Walk the scan order backwards, so the earliest requesting port in scan
    // order is the last one written and therefore wins.
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = GID_W'((int'(start_ptr) + k) % NUM_PORTS);
      if (req[cand]) winner = cand;
    end
  end

  // Access sequencer. Each output is registered here. An asynchronous reset
  // drops any access in flight without sending an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      last      <= GID_W'(NUM_PORTS - 1);
      ack       <= '0;
      rdata     <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_be    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (|req) begin
            grant_id  <= winner;
            ram_addr  <= addr[winner*ADDR_W +: ADDR_W];
            ram_wdata <= wdata[winner*DATA_W +: DATA_W];
            ram_we    <= we[winner];
            // Reads enable every lane, so the RAM returns the full word.
            ram_be    <= we[winner] ? be[winner*BE_W +: BE_W] : {BE_W{1'b1}};
            ram_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          ram_en  <= 1'b0;
          lat_cnt <= 3'd1;
          state   <= WAIT;
        end
        WAIT: begin
          lat_cnt <= lat_cnt + 3'd1;
          if (lat_cnt == LAT_END) begin
            // Only a read updates rdata, and only the granted port's slice.
            if (!ram_we) rdata[grant_id*DATA_W +: DATA_W] <= ram_rdata;
            ack[grant_id] <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          ack  <= '0;
          busy <= 1'b0;
          if (ARB_MODE == 0) last <= grant_id;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
